// File: rtl/multicycle_bus_adapter.sv
// Bridges the multicycle controller's single-cycle memory strobes onto a
// valid/ready request bus with variable-latency responses. Holds the core
// with stall while a transaction is outstanding, builds byte strobes for
// sub-word stores and formats (aligns, sign/zero-extends) load data.
module multicycle_bus_adapter #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            mem_read_enable,
    input  logic            mem_write_enable,
    input  logic            inst_or_data,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] data_addr,
    input  logic [XLEN-1:0] store_data,
    input  logic [2:0]      funct3,
    output logic            stall,
    output logic [XLEN-1:0] read_data,
    output logic            misaligned,
    output logic            bus_req_valid,
    input  logic            bus_req_ready,
    output logic [XLEN-1:0] bus_addr,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_wdata,
    output logic [3:0]      bus_wstrb,
    input  logic            bus_resp_valid,
    input  logic [XLEN-1:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     bus_addr_q, bus_addr_d;
    logic            bus_we_q, bus_we_d;
    logic [31:0]     bus_wdata_q, bus_wdata_d;
    logic [3:0]      bus_wstrb_q, bus_wstrb_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [1:0]      offset_q, offset_d;
    logic [31:0]     read_data_q, read_data_d;
    logic            misaligned_q, misaligned_d;

    logic            strobe_s;
    logic [31:0]     req_addr_s;
    logic [2:0]      eff_funct3_s;
    logic            misalign_s;

    // Byte enables for a store of the given size at byte offset off.
    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] strb;
        case (f3[1:0])
            2'b00:   strb = 4'b0001 << off;
            2'b01:   strb = 4'b0011 << off;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

    // Replicate the stored byte/half across all lanes so any offset works.
    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        case (f3[1:0])
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    // Shift the addressed bytes down to bit 0 and extend per the access type.
    function automatic logic [31:0] load_format(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] rdata);
        logic [31:0] s;
        logic [31:0] r;
        s = rdata >> {off, 3'b000};
        case (f3)
            3'b000:  r = {{24{s[7]}}, s[7:0]};
            3'b100:  r = {24'h000000, s[7:0]};
            3'b001:  r = {{16{s[15]}}, s[15:0]};
            3'b101:  r = {16'h0000, s[15:0]};
            default: r = s;
        endcase
        return r;
    endfunction

    // Request decode: fetches are always word accesses; a write wins over a read.
    always_comb begin
        strobe_s     = mem_read_enable | mem_write_enable;
        req_addr_s   = inst_or_data ? data_addr : pc;
        eff_funct3_s = (mem_write_enable || inst_or_data) ? funct3 : 3'b010;
        if (eff_funct3_s[1:0] == 2'b00) begin
            misalign_s = 1'b0;
        end else if (eff_funct3_s[1:0] == 2'b01) begin
            misalign_s = req_addr_s[0];
        end else begin
            misalign_s = (req_addr_s[1:0] != 2'b00);
        end
    end

    // Next-state and captured-field logic for the transaction FSM.
    always_comb begin
        state_d      = state_q;
        bus_addr_d   = bus_addr_q;
        bus_we_d     = bus_we_q;
        bus_wdata_d  = bus_wdata_q;
        bus_wstrb_d  = bus_wstrb_q;
        funct3_d     = funct3_q;
        offset_d     = offset_q;
        read_data_d  = read_data_q;
        misaligned_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (strobe_s) begin
                    bus_addr_d  = {req_addr_s[31:2], 2'b00};
                    bus_we_d    = mem_write_enable;
                    bus_wdata_d = mem_write_enable ? store_lanes(eff_funct3_s, store_data) : 32'h0000_0000;
                    bus_wstrb_d = mem_write_enable ? store_strb(eff_funct3_s, req_addr_s[1:0]) : 4'b0000;
                    funct3_d    = eff_funct3_s;
                    offset_d    = req_addr_s[1:0];
                    if (misalign_s) begin
                        state_d      = DONE;
                        misaligned_d = 1'b1;
                        read_data_d  = 32'h0000_0000;
                    end else begin
                        state_d = REQ;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (bus_req_ready) begin
                    state_d = WAIT;
                end else begin
                    state_d = REQ;
                end
            end
            WAIT: begin
                if (bus_resp_valid) begin
                    state_d = DONE;
                    if (!bus_we_q) begin
                        read_data_d = load_format(funct3_q, offset_q, bus_rdata);
                    end else begin
                        read_data_d = read_data_q;
                    end
                end else begin
                    state_d = WAIT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and captured-field registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            bus_addr_q   <= 32'h0000_0000;
            bus_we_q     <= 1'b0;
            bus_wdata_q  <= 32'h0000_0000;
            bus_wstrb_q  <= 4'b0000;
            funct3_q     <= 3'b000;
            offset_q     <= 2'b00;
            read_data_q  <= 32'h0000_0000;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bus_addr_q   <= bus_addr_d;
            bus_we_q     <= bus_we_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_wstrb_q  <= bus_wstrb_d;
            funct3_q     <= funct3_d;
            offset_q     <= offset_d;
            read_data_q  <= read_data_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign stall         = ((state_q == IDLE) && strobe_s) || (state_q == REQ) || (state_q == WAIT);
    assign bus_req_valid = (state_q == REQ);
    assign bus_addr      = bus_addr_q;
    assign bus_we        = bus_we_q;
    assign bus_wdata     = bus_wdata_q;
    assign bus_wstrb     = bus_wstrb_q;
    assign read_data     = read_data_q;
    assign misaligned    = misaligned_q;

endmodule

// File: tb/tb_multicycle_bus_adapter.sv
// Directed self-checking bench for multicycle_bus_adapter.
module tb_multicycle_bus_adapter;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_read_enable, mem_write_enable, inst_or_data;
    logic [31:0] pc, data_addr, store_data;
    logic [2:0]  funct3;
    logic        stall, misaligned;
    logic [31:0] read_data;
    logic        bus_req_valid, bus_req_ready, bus_we, bus_resp_valid;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_wstrb;

    int checks = 0;
    int errors = 0;

    multicycle_bus_adapter #(.XLEN(32)) dut (
        .clock(clock), .reset(reset),
        .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
        .inst_or_data(inst_or_data), .pc(pc), .data_addr(data_addr),
        .store_data(store_data), .funct3(funct3),
        .stall(stall), .read_data(read_data), .misaligned(misaligned),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
        .bus_addr(bus_addr), .bus_we(bus_we), .bus_wdata(bus_wdata),
        .bus_wstrb(bus_wstrb), .bus_resp_valid(bus_resp_valid), .bus_rdata(bus_rdata)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One full bus access with rdly cycles of ready low in REQ.
    task automatic access(input string tag, input logic re, input logic we, input logic ido,
                          input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] sd,
                          input logic [31:0] rdata, input int rdly,
                          input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                          input logic [3:0] exp_wstrb, input logic [31:0] exp_rd);
        // IDLE with strobe
        mem_read_enable = re; mem_write_enable = we; inst_or_data = ido;
        pc = addr; data_addr = ido ? addr : 32'h0000_0000; funct3 = f3; store_data = sd;
        bus_req_ready = 1'b0; bus_resp_valid = 1'b0;
        #1;
        check({tag, ".idle_stall"}, {31'd0, stall}, 32'd1);
        check({tag, ".idle_valid"}, {31'd0, bus_req_valid}, 32'd0);
        @(negedge clock);
        // REQ, ready low for rdly cycles then high
        for (int i = 0; i <= rdly; i++) begin
            bus_req_ready = (i == rdly);
            bus_resp_valid = (i == rdly);  // response in acceptance cycle must be ignored
            bus_rdata = 32'hDEAD_DEAD;
            #1;
            check({tag, ".req_valid"}, {31'd0, bus_req_valid}, 32'd1);
            check({tag, ".req_stall"}, {31'd0, stall}, 32'd1);
            check({tag, ".addr"}, bus_addr, exp_addr);
            check({tag, ".we"}, {31'd0, bus_we}, {31'd0, we});
            check({tag, ".wdata"}, bus_wdata, exp_wdata);
            check({tag, ".wstrb"}, {28'd0, bus_wstrb}, {28'd0, exp_wstrb});
            @(negedge clock);
        end
        // WAIT, first cycle without response proves the early one was dropped
        bus_req_ready = 1'b0; bus_resp_valid = 1'b0;
        #1;
        check({tag, ".wait_stall"}, {31'd0, stall}, 32'd1);
        check({tag, ".wait_valid"}, {31'd0, bus_req_valid}, 32'd0);
        @(negedge clock);
        bus_resp_valid = 1'b1; bus_rdata = rdata;
        #1;
        check({tag, ".wait2_stall"}, {31'd0, stall}, 32'd1);
        @(negedge clock);
        // DONE
        bus_resp_valid = 1'b0; bus_rdata = 32'h0000_0000;
        #1;
        check({tag, ".done_stall"}, {31'd0, stall}, 32'd0);
        check({tag, ".done_mis"}, {31'd0, misaligned}, 32'd0);
        check({tag, ".rdata"}, read_data, exp_rd);
        mem_read_enable = 1'b0; mem_write_enable = 1'b0;
        @(negedge clock);
        #1;
        check({tag, ".back_idle"}, {30'd0, stall, bus_req_valid}, 32'd0);
        @(negedge clock);
    endtask

    // Misaligned access: IDLE -> DONE with no bus request.
    task automatic misaligned_access(input string tag, input logic we, input logic [31:0] addr,
                                     input logic [2:0] f3);
        mem_read_enable = ~we; mem_write_enable = we; inst_or_data = 1'b1;
        data_addr = addr; funct3 = f3; store_data = 32'h1234_5678;
        #1;
        check({tag, ".idle_stall"}, {31'd0, stall}, 32'd1);
        check({tag, ".idle_valid"}, {31'd0, bus_req_valid}, 32'd0);
        @(negedge clock);
        #1;
        check({tag, ".done_stall"}, {31'd0, stall}, 32'd0);
        check({tag, ".done_valid"}, {31'd0, bus_req_valid}, 32'd0);
        check({tag, ".pulse"}, {31'd0, misaligned}, 32'd1);
        check({tag, ".rdata"}, read_data, 32'h0000_0000);
        mem_read_enable = 1'b0; mem_write_enable = 1'b0;
        @(negedge clock);
        #1;
        check({tag, ".pulse_end"}, {31'd0, misaligned}, 32'd0);
        check({tag, ".idle_valid2"}, {31'd0, bus_req_valid}, 32'd0);
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1;
        mem_read_enable = 1'b0; mem_write_enable = 1'b0; inst_or_data = 1'b0;
        pc = 32'h0; data_addr = 32'h0; store_data = 32'h0; funct3 = 3'b000;
        bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_rdata = 32'h0;
        @(negedge clock);
        @(negedge clock);
        check("rst.stall", {31'd0, stall}, 32'd0);
        check("rst.rdata", read_data, 32'h0);
        check("rst.mis", {31'd0, misaligned}, 32'd0);
        check("rst.valid", {31'd0, bus_req_valid}, 32'd0);
        check("rst.addr", bus_addr, 32'h0);
        check("rst.we", {31'd0, bus_we}, 32'd0);
        check("rst.wdata", bus_wdata, 32'h0);
        check("rst.wstrb", {28'd0, bus_wstrb}, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        //     tag     re    we    ido   addr          f3      store_data     bus_rdata      rdly exp_addr      exp_wdata      strb     exp_read_data
        access("fetch", 1'b1, 1'b0, 1'b0, 32'h0000_0100, 3'b010, 32'h0,        32'h0050_0093, 0, 32'h0000_0100, 32'h0,        4'b0000, 32'h0050_0093);
        access("fetchb",1'b1, 1'b0, 1'b0, 32'h0000_0104, 3'b000, 32'h0,        32'hCAFE_BABE, 1, 32'h0000_0104, 32'h0,        4'b0000, 32'hCAFE_BABE);
        access("lb",    1'b1, 1'b0, 1'b1, 32'h0000_0203, 3'b000, 32'h0,        32'h80FF_1234, 0, 32'h0000_0200, 32'h0,        4'b0000, 32'hFFFF_FF80);
        access("lbu",   1'b1, 1'b0, 1'b1, 32'h0000_0203, 3'b100, 32'h0,        32'h80FF_1234, 0, 32'h0000_0200, 32'h0,        4'b0000, 32'h0000_0080);
        access("lh",    1'b1, 1'b0, 1'b1, 32'h0000_0202, 3'b001, 32'h0,        32'h80FF_1234, 0, 32'h0000_0200, 32'h0,        4'b0000, 32'hFFFF_80FF);
        access("lhu",   1'b1, 1'b0, 1'b1, 32'h0000_0202, 3'b101, 32'h0,        32'h80FF_1234, 0, 32'h0000_0200, 32'h0,        4'b0000, 32'h0000_80FF);
        access("lw",    1'b1, 1'b0, 1'b1, 32'h0000_0204, 3'b010, 32'h0,        32'h8765_4321, 0, 32'h0000_0204, 32'h0,        4'b0000, 32'h8765_4321);
        access("sh",    1'b0, 1'b1, 1'b1, 32'h0000_0302, 3'b001, 32'hDEAD_BEEF,32'h1111_1111, 3, 32'h0000_0300, 32'hBEEF_BEEF, 4'b1100, 32'h8765_4321);
        access("sb",    1'b0, 1'b1, 1'b1, 32'h0000_0301, 3'b000, 32'h0000_00A5,32'h2222_2222, 0, 32'h0000_0300, 32'hA5A5_A5A5, 4'b0010, 32'h8765_4321);
        access("sw",    1'b0, 1'b1, 1'b1, 32'h0000_0300, 3'b010, 32'h1234_5678,32'h3333_3333, 2, 32'h0000_0300, 32'h1234_5678, 4'b1111, 32'h8765_4321);

        misaligned_access("mis_lw", 1'b0, 32'h0000_0401, 3'b010);
        misaligned_access("mis_sh", 1'b1, 32'h0000_0403, 3'b001);

        // Reset in WAIT, then a late response
        mem_read_enable = 1'b1; inst_or_data = 1'b1; data_addr = 32'h0000_0500; funct3 = 3'b010;
        bus_req_ready = 1'b1;
        @(negedge clock);            // REQ
        @(negedge clock);            // WAIT
        bus_req_ready = 1'b0;
        #1;
        check("rstw.in_wait", {30'd0, stall, bus_req_valid}, 32'd2);
        reset = 1'b1;
        mem_read_enable = 1'b0;
        #1;
        check("rstw.valid", {31'd0, bus_req_valid}, 32'd0);
        check("rstw.stall", {31'd0, stall}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        bus_resp_valid = 1'b1; bus_rdata = 32'h1234_5678;
        @(negedge clock);
        @(negedge clock);
        bus_resp_valid = 1'b0;
        #1;
        check("rstw.idle_valid", {31'd0, bus_req_valid}, 32'd0);
        check("rstw.idle_stall", {31'd0, stall}, 32'd0);
        check("rstw.rdata", read_data, 32'h0000_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
